cell_eval_sequencer: RTL

- Sequences a 3-input / 2-output transistor-level logic cell, such as the team's switch-level cells with rise/fall/turn-off delays.
- Drives the cell's a/b/c inputs from registers and waits a programmable settle interval covering the cell's propagation delay.
- Captures Y1/Y0, compares the capture against a golden truth table, and returns the result through a valid/ready handshake.
- Offers single-vector requests and an automatic 8-vector exhaustive sweep with a mismatch counter; used as the on-chip checker/wrapper around delay-annotated cells.

---
 rtl/cell_eval_pkg.sv | 8 +
 rtl/cell_eval_golden.sv | 11 +
 rtl/cell_eval_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cell_eval_pkg.sv
// cell_eval_pkg: shared types and the default full-adder golden table for the cell sequencer
package cell_eval_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  typedef logic [2:0] vec_t;
  typedef logic [1:0] res_t;
  // {carry,sum} for v = {a,b,c}, two bits per vector, v=0 in the low bits
  localparam logic [15:0] GOLDEN_FA = 16'hE994;
endpackage

// File: rtl/cell_eval_golden.sv
// cell_eval_golden: combinational lookup of the expected {Y1,Y0} for a vector {a,b,c}
module cell_eval_golden
  import cell_eval_pkg::*;
#(
  parameter logic [15:0] GOLDEN = GOLDEN_FA
) (
  input  logic [2:0] abc,
  output logic [1:0] y
);
  assign y = GOLDEN[{abc, 1'b0} +: 2];
endmodule

// File: rtl/cell_eval_sequencer.sv
// cell_eval_sequencer: drives a 3-input cell, waits a settle interval, captures Y and checks it against a golden table
module cell_eval_sequencer
  import cell_eval_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] GOLDEN        = GOLDEN_FA,
  parameter int          ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_abc,
  input  logic             sweep_start,
  output logic             busy,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_c,
  input  logic             cell_y1,
  input  logic             cell_y0,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_abc,
  output logic [1:0]       rsp_y,
  output logic             rsp_mismatch,
  output logic             sweep_done,
  output logic [ERR_W-1:0] err_count
);
  state_t state, state_d;
  vec_t vec, vec_d, abc_d;
  res_t gold_y, y_d;
  logic [7:0] cnt, cnt_d;
  logic sweep, sweep_d, valid_d, mis_d, done_d;
  logic [ERR_W-1:0] err_d;

  cell_eval_golden #(.GOLDEN(GOLDEN)) u_golden (.abc(vec), .y(gold_y));

  assign {cell_a, cell_b, cell_c} = vec;
  assign busy = state != IDLE;

  always_comb begin
    state_d = state;
    vec_d = vec;
    cnt_d = cnt;
    sweep_d = sweep;
    err_d = err_count;
    valid_d = rsp_valid;
    abc_d = rsp_abc;
    y_d = rsp_y;
    mis_d = rsp_mismatch;
    done_d = 1'b0;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !sweep_start && !rst;
        if (sweep_start) begin
          vec_d = '0;
          cnt_d = 8'(SETTLE_CYCLES);
          sweep_d = 1'b1;
          err_d = '0;
          state_d = SETTLE;
        end else if (req_valid) begin
          vec_d = req_abc;
          cnt_d = 8'(SETTLE_CYCLES);
          sweep_d = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt - 8'd1;
        if (cnt == 8'd1) begin
          y_d = {cell_y1, cell_y0};
          abc_d = vec;
          mis_d = {cell_y1, cell_y0} != gold_y;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        valid_d = 1'b0;
        err_d = (rsp_mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
        if (sweep && vec != 3'd7) begin
          vec_d = vec + 3'd1;
          cnt_d = 8'(SETTLE_CYCLES);
          state_d = SETTLE;
        end else begin
          done_d = sweep;
          sweep_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      cnt <= '0;
      sweep <= 1'b0;
      err_count <= '0;
      rsp_valid <= 1'b0;
      rsp_abc <= '0;
      rsp_y <= '0;
      rsp_mismatch <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_d;
      vec <= vec_d;
      cnt <= cnt_d;
      sweep <= sweep_d;
      err_count <= err_d;
      rsp_valid <= valid_d;
      rsp_abc <= abc_d;
      rsp_y <= y_d;
      rsp_mismatch <= mis_d;
      sweep_done <= done_d;
    end
endmodule
